ssd_scan: RTL
=============

SSD_SCAN -- requirements
Module: ssd_scan

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 2: dead-time cycles per digit slot with all anodes off; legal values are 1 or more.
REQ-002 SHALL have parameter ON_CYCLES, default 1000: lit-window cycles per digit slot; legal values are 4 or more and a multiple of 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: scan enable.
REQ-006 SHALL have port dig_1, input, 7 bits: segment pattern for digit 0 (hundreds), active-high, bit0 = segment a.
REQ-007 SHALL have port dig_2, input, 7 bits: segment pattern for digit 1 (tens).
REQ-008 SHALL have port dig_3, input, 7 bits: segment pattern for digit 2 (units).
REQ-009 SHALL have port seg, output, 7 bits: shared segment bus, active-high.
REQ-010 SHALL have port an, output, 3 bits: digit anodes, active-low, an[i] selects digit i.
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-012 SHALL use a two-state FSM, BLANK and ON, with a cycle counter cnt and a digit index idx in the range 0..2.
REQ-013 SHALL, in BLANK, count cnt from 0 to BLANK_CYCLES-1, then enter ON with cnt=0.
REQ-014 SHALL, in ON, count cnt from 0 to ON_CYCLES-1, then enter BLANK with cnt=0 and idx incremented; idx wraps from 2 to 0.
REQ-015 SHALL define one frame as 3*(BLANK_CYCLES+ON_CYCLES) cycles.
REQ-016 SHALL load the snapshot registers from dig_1, dig_2 and dig_3 only in the cycle where state=BLANK, idx=0, cnt=0 and en=1, so that no digit tears within a frame.
REQ-017 SHALL register all outputs with a latency of one cycle from the state: in the cycle after a state cycle with state=ON, an[idx]=0, the other anode bits=1, and seg=snap[idx].
REQ-018 SHALL hold an=3'b111 and seg=7'b0 in the cycle after any BLANK state cycle.
REQ-019 SHALL never drive more than one bit of an low in any cycle.
REQ-020 SHALL assert frame_start in the cycle after the snapshot-load cycle.
REQ-021 SHALL, while en=0, force state=BLANK, idx=0 and cnt=0, with an=3'b111, seg=0 and frame_start=0 on the following cycle.
REQ-022 SHALL, when en returns to 1, begin a fresh frame that includes a new snapshot.
REQ-023 SHALL ignore changes on dig_1, dig_2 and dig_3 in every cycle other than the snapshot-load cycle.

Reset
REQ-024 SHALL, with rst=1 at a rising edge, set state=BLANK, idx=0, cnt=0, all snapshot registers to 0, an=3'b111, seg=7'b0 and frame_start=0.
REQ-025 SHALL give rst priority over en.
REQ-026 SHALL, when rst is asserted mid-slot, abort that slot immediately and start the first post-reset frame at digit 0 BLANK.

Configuration
REQ-027 SHALL, when macro SSD_SCAN_BRIGHTNESS_EN is defined, add input port bright (2 bits), sampled into the snapshot together with the digits.
REQ-028 SHALL, when SSD_SCAN_BRIGHTNESS_EN is defined, drive the anode low only for ON-state cycles with cnt < (bright+1)*ON_CYCLES/4, and hold an=3'b111 and seg=0 for the rest of the ON window.
REQ-029 SHALL, when SSD_SCAN_BRIGHTNESS_EN is undefined, omit the bright port and light the digit for the full ON window, with timing identical to bright=3.

Structure
REQ-030 SHALL place the following in package ssd_scan_pkg: NUM_DIGITS=3, the state enum (BLANK, ON), the digit index typedef (2 bits) and the segment typedef (7 bits).
REQ-031 SHALL put the cnt counter and its terminal-count compare in sub-module ssd_scan_timer, with its load value selected by state; the FSM, snapshot logic and output registers stay in ssd_scan.

Verification (BLANK_CYCLES=2, ON_CYCLES=8 for all scenarios)
REQ-032 Reset and basic scan: release rst, then en=1 with dig_1=7'h06, dig_2=7'h5B, dig_3=7'h4F -> frame_start pulses at cycle 1; an=3'b110 and seg=7'h06 for cycles 3-10; all off for cycles 11-12; an=3'b101 and seg=7'h5B for cycles 13-20; the frame period is 30 cycles.
REQ-033 Snapshot stability: change dig_2 to 7'h7F during digit 0 ON -> seg stays 7'h5B throughout that frame's digit 1 window; seg shows 7'h7F from the next frame.
REQ-034 Mid-slot reset: assert rst for 1 cycle during digit 1 ON -> next cycle an=3'b111 and seg=0; after release, the first lit digit is digit 0 with snapshot value 0 until the next snapshot.
REQ-035 Enable drop: en=0 for 5 cycles during digit 2 -> an=3'b111 throughout; after en=1, frame_start pulses once and digit 0 lights 3 cycles later.
REQ-036 Brightness (macro defined): bright=2'b01 -> each digit lit for 4 of its 8 ON cycles; bright=2'b11 -> lit for 8 of 8; a bright change mid-frame is not applied until the next frame_start.
REQ-037 One-hot anodes: run a random-digit soak for 10 frames -> the $countones(~an) <= 1 assertion never fails.

Source files
------------

// File: rtl/ssd_scan_pkg.sv
// Shared types and constants for the three-digit seven-segment scanner.
package ssd_scan_pkg;

    localparam int NUM_DIGITS = 3;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    typedef logic [1:0] idx_t;
    typedef logic [6:0] seg_t;

endpackage

// File: rtl/ssd_scan_timer.sv
// Slot timer for the scanner: counts up from 0 and flags the last cycle of the
// current slot, whose length is chosen by the FSM state.
module ssd_scan_timer
    import ssd_scan_pkg::*;
#(
    parameter int BLANK_CYCLES = 2,
    parameter int ON_CYCLES    = 1000,
    parameter int CW           = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  state_t        state,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] last;

    always_comb begin
        last = (state == ON) ? CW'(ON_CYCLES - 1) : CW'(BLANK_CYCLES - 1);
        tc   = (cnt == last);
    end

    always_ff @(posedge clk) begin
        if (rst || clr || tc)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ssd_scan.sv
// Three-digit multiplexed seven-segment scanner with per-frame digit snapshot.
// Optional per-frame brightness control is enabled with SSD_SCAN_BRIGHTNESS_EN.
module ssd_scan
    import ssd_scan_pkg::*;
#(
    parameter int BLANK_CYCLES = 2,
    parameter int ON_CYCLES    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] dig_1,
    input  logic [6:0] dig_2,
    input  logic [6:0] dig_3,
`ifdef SSD_SCAN_BRIGHTNESS_EN
    input  logic [1:0] bright,
`endif
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_start
);

    localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC);

    state_t        state;
    idx_t          idx;
    seg_t          snap0, snap1, snap2;
    logic [CW-1:0] cnt;
    logic          tc;
    logic          load;
    logic          lit;
    seg_t          sel_seg;
    logic [2:0]    sel_an;

    ssd_scan_timer #(
        .BLANK_CYCLES(BLANK_CYCLES),
        .ON_CYCLES   (ON_CYCLES),
        .CW          (CW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (~en),
        .state(state),
        .cnt  (cnt),
        .tc   (tc)
    );

    assign load = (state == BLANK) && (idx == 2'd0) && (cnt == '0) && en;

`ifdef SSD_SCAN_BRIGHTNESS_EN
    localparam int LW = CW + 2;
    logic [1:0] bright_q;
    logic [LW-1:0] lit_len;
    always_comb begin
        lit_len = LW'((int'(bright_q) + 1) * (ON_CYCLES / 4));
        lit     = ({2'b00, cnt} < lit_len);
    end
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        case (idx)
            2'd0:    begin sel_seg = snap0; sel_an = 3'b110; end
            2'd1:    begin sel_seg = snap1; sel_an = 3'b101; end
            default: begin sel_seg = snap2; sel_an = 3'b011; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BLANK;
            idx         <= '0;
            snap0       <= '0;
            snap1       <= '0;
            snap2       <= '0;
            an          <= 3'b111;
            seg         <= '0;
            frame_start <= 1'b0;
`ifdef SSD_SCAN_BRIGHTNESS_EN
            bright_q    <= '0;
`endif
        end else if (!en) begin
            state       <= BLANK;
            idx         <= '0;
            an          <= 3'b111;
            seg         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= load;
            if (load) begin
                snap0 <= dig_1;
                snap1 <= dig_2;
                snap2 <= dig_3;
`ifdef SSD_SCAN_BRIGHTNESS_EN
                bright_q <= bright;
`endif
            end

            // Output reflects this cycle's state; snapshot is never loaded during ON.
            if (state == ON && lit) begin
                an  <= sel_an;
                seg <= sel_seg;
            end else begin
                an  <= 3'b111;
                seg <= '0;
            end

            if (tc) begin
                if (state == BLANK) begin
                    state <= ON;
                end else begin
                    state <= BLANK;
                    idx   <= (idx == idx_t'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

endmodule
